// File: rtl/vscale_hpm_counters.sv
// vscale machine counter bank: mcycle, minstret, hpmcounters,
// inhibit/enable CSRs and sticky overflow flags with interrupt.
module vscale_hpm_counters #(
  parameter int N_HPM     = 4,
  parameter int CNT_WIDTH = 64,
  parameter int N_EVENTS  = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req,
  input  logic [11:0]         addr,
  input  logic [2:0]          cmd,
  input  logic [31:0]         wdata,
  input  logic [1:0]          ms_prv,
  input  logic                retire,
  input  logic [N_EVENTS-1:0] events,
  output logic [31:0]         rdata,
  output logic                illegal_access,
  output logic [N_HPM-1:0]    ovf_flags,
  output logic                ovf_irq
);

  localparam int NC = N_HPM + 3;
  localparam logic [NC-1:0] CMASK = ~NC'(2);

  logic [CNT_WIDTH-1:0] r_cnt [NC];
  logic [N_EVENTS-1:0]  r_evt [N_HPM];
  logic [NC-1:0]        r_inh;
  logic [NC-1:0]        r_cen;
  logic [N_HPM-1:0]     r_ovf;
  logic [N_HPM-1:0]     r_ovf_en;

  logic [4:0]       w_n;
  logic [63:0]      w_ext;
  logic [63:0]      w_new;
  logic             w_cen;
  logic             w_nok;
  logic             w_is_inh;
  logic             w_is_cen;
  logic             w_is_evt;
  logic             w_is_ovf;
  logic             w_is_oen;
  logic             w_is_cnt;
  logic             w_is_shd;
  logic             w_def;
  logic [31:0]      w_evt_rd;
  logic [31:0]      w_half;
  logic [31:0]      w_wval;
  logic             w_wr;
  logic             w_we;
  logic [NC-1:0]    w_inc;
  logic [NC-1:0]    w_cwe;
  logic [N_HPM-1:0] w_ewe;
  logic [N_HPM-1:0] w_wrap;

  assign w_n = addr[4:0];

  always_comb begin
    w_ext = '0;
    w_cen = 1'b0;
    w_nok = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (i != 1 && w_n == 5'(i)) begin
        w_ext = 64'(r_cnt[i]);
        w_cen = r_cen[i];
        w_nok = 1'b1;
      end
    end
  end

  always_comb begin
    w_is_evt = 1'b0;
    w_evt_rd = '0;
    w_ewe    = '0;
    for (int i = 0; i < N_HPM; i++) begin
      if (addr == 12'(12'h323 + i)) begin
        w_is_evt = 1'b1;
        w_evt_rd = 32'(r_evt[i]);
        w_ewe[i] = w_we;
      end
    end
  end

  assign w_is_inh = (addr == 12'h320);
  assign w_is_cen = (addr == 12'h306);
  assign w_is_ovf = (addr == 12'h7C0);
  assign w_is_oen = (addr == 12'h7C1);
  assign w_is_cnt = (addr[11:8] == 4'hB) &&
                    (addr[6:5] == 2'b00) && w_nok;
  assign w_is_shd = (addr[11:8] == 4'hC) &&
                    (addr[6:5] == 2'b00) && w_nok;
  assign w_def = w_is_inh | w_is_cen | w_is_evt |
                 w_is_ovf | w_is_oen | w_is_cnt |
                 w_is_shd;
  assign w_half = addr[7] ? w_ext[63:32] : w_ext[31:0];

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      w_is_inh: rdata = 32'(r_inh);
      w_is_cen: rdata = 32'(r_cen);
      w_is_evt: rdata = w_evt_rd;
      w_is_ovf: rdata = 32'(r_ovf);
      w_is_oen: rdata = 32'(r_ovf_en);
      w_is_cnt,
      w_is_shd: rdata = w_half;
      default:  rdata = '0;
    endcase
  end

  assign w_wr = cmd[2] & (cmd[1] | cmd[0]);
  assign illegal_access = cmd[2] & (
    ~w_def |
    (addr[9:8] > ms_prv) |
    (w_wr & (addr[11:10] == 2'b11)) |
    (w_is_shd & (ms_prv == 2'b00) & ~w_cen));
  assign w_we = req & w_wr & ~illegal_access;

  always_comb begin
    case (cmd[1:0])
      2'b10:   w_wval = rdata | wdata;
      2'b11:   w_wval = rdata & ~wdata;
      default: w_wval = wdata;
    endcase
  end

  // half-word writes keep the other half as is, no carry
  assign w_new = addr[7] ? {w_wval, w_ext[31:0]}
                         : {w_ext[63:32], w_wval};

  always_comb begin
    w_inc    = '0;
    w_inc[0] = ~r_inh[0];
    w_inc[2] = retire & ~r_inh[2];
    w_wrap   = '0;
    for (int i = 0; i < N_HPM; i++) begin
      w_inc[i+3] = (|(events & r_evt[i])) & ~r_inh[i+3];
    end
    for (int i = 0; i < NC; i++) begin
      w_cwe[i] = w_we & w_is_cnt & (w_n == 5'(i));
    end
    for (int i = 0; i < N_HPM; i++) begin
      w_wrap[i] = w_inc[i+3] & ~w_cwe[i+3] &
                  (&r_cnt[i+3]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NC; i++) r_cnt[i] <= '0;
      for (int i = 0; i < N_HPM; i++) r_evt[i] <= '0;
      r_inh    <= '0;
      r_cen    <= '0;
      r_ovf    <= '0;
      r_ovf_en <= '0;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (w_cwe[i])
          r_cnt[i] <= w_new[CNT_WIDTH-1:0];
        else if (w_inc[i])
          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end
      for (int i = 0; i < N_HPM; i++) begin
        if (w_ewe[i])
          r_evt[i] <= w_wval[N_EVENTS-1:0];
      end
      if (w_we && w_is_inh)
        r_inh <= w_wval[NC-1:0] & CMASK;
      if (w_we && w_is_cen)
        r_cen <= w_wval[NC-1:0] & CMASK;
      if (w_we && w_is_oen)
        r_ovf_en <= w_wval[N_HPM-1:0];
      // a wrap on the same edge beats a clear
      r_ovf <= (r_ovf & ~((w_we && w_is_ovf) ?
                 w_wval[N_HPM-1:0] : '0)) | w_wrap;
    end
  end

  assign ovf_flags = r_ovf;
  assign ovf_irq   = |(r_ovf & r_ovf_en);

endmodule

// File: tb/tb_vscale_hpm_counters.sv
// Directed bench for vscale_hpm_counters with a queue scoreboard
// checked by a monitor on the falling clock edge.
module tb_vscale_hpm_counters;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic [11:0] addr;
  logic [2:0]  cmd;
  logic [31:0] wdata;
  logic [1:0]  ms_prv;
  logic        retire;
  logic [7:0]  events;
  logic [31:0] rdata;
  logic        illegal_access;
  logic [3:0]  ovf_flags;
  logic        ovf_irq;

  vscale_hpm_counters #(
    .N_HPM(4), .CNT_WIDTH(40), .N_EVENTS(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .addr(addr), .cmd(cmd), .wdata(wdata),
    .ms_prv(ms_prv), .retire(retire),
    .events(events), .rdata(rdata),
    .illegal_access(illegal_access),
    .ovf_flags(ovf_flags), .ovf_irq(ovf_irq)
  );

  typedef struct {
    string       name;
    logic [31:0] rd;
    bit          ill;
    bit          crd;
    bit          cirq;
    bit          irq;
    logic [3:0]  flg;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   ncmp = 0;
  int   nmis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (req && cmd[2]) begin
      if (q.size() == 0) begin
        ncmp++; nmis++;
        $display("FAIL unexpected access addr=%h", addr);
      end else begin
        e = q.pop_front();
        ncmp++;
        if (illegal_access !== e.ill) begin
          nmis++;
          $display("FAIL %s illegal got %b want %b",
                   e.name, illegal_access, e.ill);
        end
        if (e.crd) begin
          ncmp++;
          if (rdata !== e.rd) begin
            nmis++;
            $display("FAIL %s rdata got %h want %h",
                     e.name, rdata, e.rd);
          end
        end
        if (e.cirq) begin
          ncmp++;
          if (ovf_irq !== e.irq || ovf_flags !== e.flg) begin
            nmis++;
            $display("FAIL %s irq/flags got %b/%h want %b/%h",
                     e.name, ovf_irq, ovf_flags, e.irq, e.flg);
          end
        end
      end
    end
  end

  task automatic acc(input string nm, input logic [2:0] c,
                     input logic [11:0] a, input logic [31:0] wd,
                     input logic [1:0] prv, input logic [31:0] erd,
                     input bit eill, input bit crd, input bit cirq,
                     input bit eirq, input logic [3:0] eflg);
    exp_t x;
    x.name = nm; x.rd = erd; x.ill = eill; x.crd = crd;
    x.cirq = cirq; x.irq = eirq; x.flg = eflg;
    q.push_back(x);
    req = 1'b1; cmd = c; addr = a; wdata = wd; ms_prv = prv;
    @(posedge clk); #1;
    req = 1'b0; cmd = 3'd0; ms_prv = 2'd3;
  endtask

  task automatic rd(input string nm, input logic [11:0] a,
                    input logic [31:0] erd);
    acc(nm, 3'd4, a, 32'd0, 2'd3, erd, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic rdu(input string nm, input logic [11:0] a,
                     input logic [31:0] erd);
    acc(nm, 3'd4, a, 32'd0, 2'd0, erd, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic rdirq(input string nm, input logic [11:0] a,
                       input logic [31:0] erd, input bit eirq,
                       input logic [3:0] eflg);
    acc(nm, 3'd4, a, 32'd0, 2'd3, erd, 1'b0, 1'b1, 1'b1, eirq, eflg);
  endtask

  task automatic wr(input string nm, input logic [2:0] c,
                    input logic [11:0] a, input logic [31:0] wd);
    acc(nm, c, a, wd, 2'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic ill(input string nm, input logic [2:0] c,
                     input logic [11:0] a, input logic [1:0] prv);
    acc(nm, c, a, 32'd0, prv, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset_n = 1'b0; req = 1'b0; addr = '0; cmd = '0;
    wdata = '0; ms_prv = 2'd3; retire = 1'b0; events = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rd("mcycle10", 12'hB00, 32'd10);
    rd("mcycle_hi", 12'hB80, 32'd0);
    rd("minstret0", 12'hB02, 32'd0);
    wr("inh_on", 3'd5, 12'h320, 32'h1);
    rd("mcyc_hold", 12'hB00, 32'd14);
    rd("mcyc_hold2", 12'hB00, 32'd14);
    wr("inh_all", 3'd5, 12'h320, 32'hFFFF_FFFF);
    rd("inh_mask", 12'h320, 32'h7D);
    wr("inh_5", 3'd5, 12'h320, 32'h5);

    wr("evt3", 3'd5, 12'h323, 32'h5);
    events = 8'h4; idle(3);
    events = 8'h2; idle(2);
    events = 8'h1; idle(1);
    events = 8'h0;
    rd("hpm3_cnt", 12'hB03, 32'd4);
    rd("evt3_rd", 12'h323, 32'h5);
    wr("evt4_w", 3'd5, 12'h324, 32'hFFFF_FF03);
    wr("evt4_set", 3'd6, 12'h324, 32'h10);
    wr("evt4_clr", 3'd7, 12'h324, 32'h01);
    rd("evt4_rd", 12'h324, 32'h12);

    wr("oen", 3'd5, 12'h7C1, 32'h1);
    rd("oen_rd", 12'h7C1, 32'h1);
    wr("hpm3_lo", 3'd5, 12'hB03, 32'hFFFF_FFFF);
    wr("hpm3_hi", 3'd5, 12'hB83, 32'hFFFF_FFFF);
    rd("hpm3_hi40", 12'hB83, 32'hFF);
    rd("hpm3_lo1", 12'hB03, 32'hFFFF_FFFF);
    events = 8'h1; idle(1); events = 8'h0;
    rdirq("wrap", 12'hB03, 32'd0, 1'b1, 4'h1);
    rd("ovf_rd", 12'h7C0, 32'h1);
    wr("ovf_w1c", 3'd5, 12'h7C0, 32'h1);
    rdirq("ovf_clr", 12'h7C0, 32'h0, 1'b0, 4'h0);

    wr("hpm3_lo2", 3'd5, 12'hB03, 32'hFFFF_FFFF);
    wr("hpm3_hi2", 3'd5, 12'hB83, 32'hFFFF_FFFF);
    events = 8'h1;
    wr("clr_vs_wrap", 3'd5, 12'h7C0, 32'h1);
    events = 8'h0;
    rdirq("wrap_wins", 12'h7C0, 32'h1, 1'b1, 4'h1);
    wr("ovf_w1c2", 3'd5, 12'h7C0, 32'h1);
    rd("ovf_clr2", 12'h7C0, 32'h0);

    wr("inh_off", 3'd5, 12'h320, 32'h0);
    retire = 1'b1; idle(2); retire = 1'b0;
    rd("minstret2", 12'hB02, 32'd2);
    wr("mcyc_hi", 3'd5, 12'hB80, 32'h5);
    wr("mcyc_lo", 3'd5, 12'hB00, 32'h100);
    rd("mcyc_100", 12'hB00, 32'h100);
    rd("mcyc_101", 12'hB00, 32'h101);
    rd("mcyc_hi5", 12'hB80, 32'h5);

    ill("u_c00_noen", 3'd4, 12'hC00, 2'd0);
    wr("cen", 3'd5, 12'h306, 32'h1);
    rd("cen_rd", 12'h306, 32'h1);
    rdu("u_c00", 12'hC00, 32'h106);
    rdu("u_c80", 12'hC80, 32'h5);
    ill("u_wr_c00", 3'd5, 12'hC00, 2'd0);
    ill("m_wr_c00", 3'd5, 12'hC00, 2'd3);
    ill("u_rd_320", 3'd4, 12'h320, 2'd0);
    ill("undef_321", 3'd4, 12'h321, 2'd3);
    ill("time_b01", 3'd4, 12'hB01, 2'd3);
    ill("hpm_b07", 3'd4, 12'hB07, 2'd3);
    ill("u_c03_noen", 3'd4, 12'hC03, 2'd0);
    ill("u_wr_306", 3'd5, 12'h306, 2'd0);
    rd("cen_kept", 12'h306, 32'h1);

    reset_n = 1'b0;
    rd("rst_b00", 12'hB00, 32'd0);
    rd("rst_b83", 12'hB83, 32'd0);
    rd("rst_oen", 12'h7C1, 32'd0);
    rd("rst_cen", 12'h306, 32'd0);
    reset_n = 1'b1;
    rd("resume0", 12'hB00, 32'd0);
    rd("resume1", 12'hB00, 32'd1);

    idle(2);
    if (q.size() != 0) begin
      ncmp++; nmis++;
      $display("FAIL queue_drain left %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nmis);
    $finish;
  end

endmodule

// File: doc/vscale_hpm_counters.md
# vscale_hpm_counters

Parametrised machine counter bank for the vscale core. It holds mcycle, minstret and N_HPM programmable hpmcounters, each with its mhpmevent selector, plus mcountinhibit, mcounteren and a sticky overflow/interrupt extension. It attaches to the CSR read/write port alongside the main CSR file, which forwards addresses in the counter range. It generalises the fixed 64-bit cycle/instret counters to configurable width, count and event selection.

## Interface
- N_HPM, 4: programmable counters mhpmcounter3..(3+N_HPM-1); legal range 1..29.
- CNT_WIDTH, 64: implemented counter width; legal range 33..64.
- N_EVENTS, 8: width of the event bus; legal range 1..32.

- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  CSR access valid this cycle
- addr  in  12  CSR address
- cmd  in  3  CSR command: 0 idle, 4 read, 5 write, 6 set, 7 clear; bit2 = access, bit1|bit0 = write
- wdata  in  32  write operand
- ms_prv  in  2  current privilege (3 = M, 0 = U)
- retire  in  1  one instruction retired this cycle
- events  in  N_EVENTS  per-cycle event strobes
- rdata  out  32  combinational read data for addr
- illegal_access  out  1  combinational; access must trap
- ovf_flags  out  N_HPM  sticky hpmcounter overflow flags
- ovf_irq  out  1  |(ovf_flags & ovf_en)

## Operation
- Address map:
  - mcountinhibit 0x320, bits 0, 2 and 3..N_HPM+2.
  - mhpmevent 0x323+i, low N_EVENTS bits.
  - mcounteren 0x306.
  - mcycle 0xB00 / 0xB80 (high half).
  - minstret 0xB02 / 0xB82.
  - mhpmcounter 0xB03+i / 0xB83+i.
  - User read-only shadows 0xC00+n / 0xC80+n.
  - ovf_flags 0x7C0, bits [N_HPM-1:0], write-1-to-clear.
  - ovf_en 0x7C1, bits [N_HPM-1:0], read/write.
- Unimplemented bits read 0 and ignore writes. Counter bits at and above CNT_WIDTH read 0.
- Write data: set computes rdata|wdata, clear computes rdata&~wdata, write uses wdata.
- The ovf_flags register is the exception to the set/clear rule: the final write value's 1-bits clear the matching flags.
- illegal_access is asserted for any of the following:
  - cmd[2]=1 and the address is undefined.
  - addr[9:8] > ms_prv.
  - A write (cmd[1]|cmd[0]) with addr[11:10]=2'b11.
  - A U-mode read of shadow n with mcounteren[n]=0.
- When illegal_access is asserted, no state changes.
- Writes commit only when req=1 and illegal_access=0.
- Increment rules, applied each cycle and suppressed when the matching inhibit bit is set:
  - mcycle: +1 every cycle.
  - minstret: +1 when retire=1.
  - hpm i: +1 when |(events & mhpmevent_i)=1.
  - The increment is at most 1 per counter per cycle.
- Wrap-around: a counter at 2^CNT_WIDTH-1 that increments goes to 0.
  - For hpm i, the same edge sets ovf_flags[i].
  - mcycle and minstret have no flag.
- Simultaneous events:
  - A CSR write to either half of a counter wins over that counter's increment; the counter does not increment that cycle.
  - The untouched half keeps its value, with no carry.
  - A set-flag from a wrap wins over a clear write to ovf_flags in the same cycle.
- Reset values: all counters, mhpmevent, mcountinhibit, mcounteren, ovf_flags and ovf_en are 0, so ovf_irq=0.

## Timing
- rdata and illegal_access are combinational from addr, cmd and ms_prv in the same cycle. There are no wait states.
- A write commits at the clock edge that ends the req cycle and is visible on rdata the next cycle.
- Counter updates and ovf_flags changes take effect at the clock edge. ovf_irq follows one cycle after the wrapping increment.
- Reset is asynchronous: assertion mid-operation clears all state immediately; deassertion is sampled at clk.
- Counting resumes on the first edge after reset_n goes high.

## Test plan
- Reset then idle 10 cycles -> mcycle (0xB00) reads 10 and minstret reads 0. With mcountinhibit=1, mcycle holds its value.
- Write mhpmevent3=0x5; drive events=0x4 for 3 cycles, 0x2 for 2 cycles, then 0x1 for 1 cycle -> mhpmcounter3 reads 4.
- Write mhpmcounter3 low=0xFFFFFFFF and high=0xFFFFFFFF, with ovf_en=1 and the event active -> next read is 0, ovf_flags[0]=1 and ovf_irq=1. Writing 0x1 to 0x7C0 clears both.
- Write mcycle=0x100 in a cycle where mcycle would increment -> reads 0x100 the next cycle, then 0x101. The high half is unchanged.
- ms_prv=0 reading 0xC00 with mcounteren=0 -> illegal_access=1. After an M-mode write of mcounteren=1, the read returns mcycle. A write to 0xC00 is illegal in every mode.
- CNT_WIDTH=40: write 0xFFFFFFFF to 0xB80 -> reads 0xFF. Assert reset_n low mid-count -> all reads are 0 with no clock edge required.
